// File: rtl/maria_regs_if.sv
// CPU-side bus of the MARIA register window: phase enable, select, direction, offset and data.
interface maria_regs_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic              pclk0;
  logic              cs_maria;
  logic              we_b;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        db_in;
  logic [7:0]        db_out;

  modport master (output pclk0, cs_maria, we_b, addr, db_in, input db_out);
  modport slave  (input pclk0, cs_maria, we_b, addr, db_in, output db_out);
endinterface

// File: rtl/maria_regs.sv
// MARIA register bank: double-buffered palette colours, atomic DPPH/DPPL pointer,
// immediate control registers and a WSYNC ready hold released at line start.
module maria_regs #(
  parameter int unsigned NUM_PALETTES = 8,
  parameter bit          SHADOW_EN    = 1'b1,
  parameter bit          READBACK_EN  = 1'b0,
  parameter int unsigned ADDR_W       = $clog2(4 * NUM_PALETTES)
) (
  input  logic                              sysclock,
  input  logic                              reset,
  maria_regs_if.slave                       bus,
  input  logic [7:0]                        status_read,
  input  logic                              line_start,
  input  logic                              pal,
  output logic [7:0]                        ctrl,
  output logic [8*(1+3*NUM_PALETTES)-1:0]   color_map,
  output logic [7:0]                        char_base,
  output logic [7:0]                        offset,
  output logic [15:0]                       zp,
  output logic                              ready,
  output logic                              shadow_pending
);

  localparam int unsigned NumColors = 1 + 3 * NUM_PALETTES;
  localparam int unsigned IdxW      = $clog2(NumColors);

  // Word index (offset / 4) of the non-colour registers.
  localparam int RegWsync    = 1;
  localparam int RegMstat    = 2;
  localparam int RegDpph     = 3;
  localparam int RegDppl     = 4;
  localparam int RegCharbase = 5;
  localparam int RegOffset   = 6;
  localparam int RegCtrl     = 7;

  logic [7:0]  active_q [NumColors];
  logic [7:0]  active_d [NumColors];
  logic [7:0]  shadow_q [NumColors];
  logic [7:0]  shadow_d [NumColors];
  logic        pending_q, pending_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  char_base_q, char_base_d;
  logic [7:0]  offset_q, offset_d;
  logic [7:0]  dpph_q, dpph_d;
  logic [15:0] zp_q, zp_d;
  logic        ready_q, ready_d;
  logic [7:0]  db_out_q, db_out_d;

  logic              wr_en, rd_en, is_colour;
  logic [ADDR_W-3:0] word;
  logic [1:0]        sub;
  logic [IdxW-1:0]   colour_idx;

  assign wr_en = bus.pclk0 & bus.cs_maria & ~bus.we_b;
  assign rd_en = bus.pclk0 & bus.cs_maria & bus.we_b;
  assign word  = bus.addr[ADDR_W-1:2];
  assign sub   = bus.addr[1:0];

  // Offset 0 (background) plus every offset with nonzero low bits is a colour.
  always_comb begin
    is_colour  = (sub != 2'd0) || (word == '0);
    colour_idx = (sub == 2'd0) ? '0 : IdxW'(3 * int'(word) + int'(sub));
  end

  always_comb begin
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    ctrl_d      = ctrl_q;
    char_base_d = char_base_q;
    offset_d    = offset_q;
    dpph_d      = dpph_q;
    zp_d        = zp_q;
    ready_d     = ready_q;
    db_out_d    = db_out_q;

    if (line_start) ready_d = 1'b1;

    if (wr_en) begin
      if (is_colour) begin
        shadow_d[colour_idx] = bus.db_in;
        if (SHADOW_EN) pending_d = 1'b1;
        else           active_d[colour_idx] = bus.db_in;
      end else begin
        case (int'(word))
          RegWsync:    ready_d     = 1'b0;
          RegDpph:     dpph_d      = bus.db_in;
          RegDppl:     zp_d        = {dpph_q, bus.db_in};
          RegCharbase: char_base_d = bus.db_in;
          RegOffset:   offset_d    = bus.db_in;
          RegCtrl:     ctrl_d      = bus.db_in;
          default:     ;
        endcase
      end
    end

    if (rd_en) begin
      db_out_d = 8'h00;
      if (!is_colour && int'(word) == RegMstat) begin
        db_out_d = status_read;
      end else if (READBACK_EN) begin
        if (is_colour) begin
          db_out_d = shadow_q[colour_idx];
        end else begin
          case (int'(word))
            RegDpph:     db_out_d = dpph_q;
            RegDppl:     db_out_d = zp_q[7:0];
            RegCharbase: db_out_d = char_base_q;
            RegOffset:   db_out_d = offset_q;
            RegCtrl:     db_out_d = ctrl_q;
            default:     db_out_d = 8'h00;
          endcase
        end
      end
    end

    // Commit sees this cycle's colour write, so nothing is left pending.
    if (SHADOW_EN && line_start) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge sysclock) begin
    if (reset) begin
      for (int i = 0; i < int'(NumColors); i++) begin
        active_q[i] <= 8'h00;
        shadow_q[i] <= 8'h00;
      end
      pending_q   <= 1'b0;
      ctrl_q      <= 8'h70;
      char_base_q <= 8'h00;
      offset_q    <= 8'h00;
      dpph_q      <= pal ? 8'h27 : 8'h00;
      zp_q        <= pal ? 16'h2730 : 16'h0084;
      ready_q     <= 1'b1;
      db_out_q    <= 8'h00;
    end else begin
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      ctrl_q      <= ctrl_d;
      char_base_q <= char_base_d;
      offset_q    <= offset_d;
      dpph_q      <= dpph_d;
      zp_q        <= zp_d;
      ready_q     <= ready_d;
      db_out_q    <= db_out_d;
    end
  end

  always_comb begin
    color_map = '0;
    for (int i = 0; i < int'(NumColors); i++) color_map[i*8 +: 8] = active_q[i];
  end

  assign bus.db_out     = db_out_q;
  assign ctrl           = ctrl_q;
  assign char_base      = char_base_q;
  assign offset         = offset_q;
  assign zp             = zp_q;
  assign ready          = ready_q;
  assign shadow_pending = pending_q;

endmodule

// File: tb/tb_maria_regs.sv
// Scoreboard bench: two 16-palette instances (shadowed+readback, immediate+no readback)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_maria_regs;

  localparam int NP  = 16;
  localparam int AW  = 6;
  localparam int NC  = 1 + 3 * NP;
  localparam int CMW = 8 * NC;

  typedef struct {
    logic [7:0]     ctrl, cb, off, dbo;
    logic [15:0]    zp;
    logic           rdy, pend;
    logic [CMW-1:0] cmap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, pclk0, cs, we_b, line_start, pal;
  logic [AW-1:0] addr;
  logic [7:0]    db_in, status_read;

  logic [7:0]     ctrl_o [2];
  logic [7:0]     cb_o   [2];
  logic [7:0]     off_o  [2];
  logic [7:0]     dbo_o  [2];
  logic [15:0]    zp_o   [2];
  logic           rdy_o  [2];
  logic           pend_o [2];
  logic [CMW-1:0] cmap_o [2];

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, one copy per instance; instance 0 shadows and reads back.
  logic [7:0]  m_act [2][NC];
  logic [7:0]  m_shd [2][NC];
  logic [7:0]  m_ctrl [2], m_cb [2], m_off [2], m_dpph [2], m_dbo [2];
  logic [15:0] m_zp [2];
  logic        m_rdy [2], m_pend [2];

  always #5 clk = ~clk;

  maria_regs_if #(.ADDR_W(AW)) bus_a ();
  maria_regs_if #(.ADDR_W(AW)) bus_b ();

  assign bus_a.pclk0 = pclk0;  assign bus_b.pclk0 = pclk0;
  assign bus_a.cs_maria = cs;  assign bus_b.cs_maria = cs;
  assign bus_a.we_b = we_b;    assign bus_b.we_b = we_b;
  assign bus_a.addr = addr;    assign bus_b.addr = addr;
  assign bus_a.db_in = db_in;  assign bus_b.db_in = db_in;
  assign dbo_o[0] = bus_a.db_out;
  assign dbo_o[1] = bus_b.db_out;

  maria_regs #(.NUM_PALETTES(NP), .SHADOW_EN(1'b1), .READBACK_EN(1'b1)) dut_a (
    .sysclock(clk), .reset(reset), .bus(bus_a), .status_read(status_read),
    .line_start(line_start), .pal(pal), .ctrl(ctrl_o[0]), .color_map(cmap_o[0]),
    .char_base(cb_o[0]), .offset(off_o[0]), .zp(zp_o[0]), .ready(rdy_o[0]),
    .shadow_pending(pend_o[0])
  );

  maria_regs #(.NUM_PALETTES(NP), .SHADOW_EN(1'b0), .READBACK_EN(1'b0)) dut_b (
    .sysclock(clk), .reset(reset), .bus(bus_b), .status_read(status_read),
    .line_start(line_start), .pal(pal), .ctrl(ctrl_o[1]), .color_map(cmap_o[1]),
    .char_base(cb_o[1]), .offset(off_o[1]), .zp(zp_o[1]), .ready(rdy_o[1]),
    .shadow_pending(pend_o[1])
  );

  function automatic logic [7:0] read_value(input int k, input int o);
    if (o == 0 || o % 4 != 0) return m_shd[k][(o == 0) ? 0 : 3 * (o / 4) + o % 4];
    case (o)
      12:      return m_dpph[k];
      16:      return m_zp[k][7:0];
      20:      return m_cb[k];
      24:      return m_off[k];
      28:      return m_ctrl[k];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input int k);
    int  o, idx;
    bit  sh;
    sh = (k == 0);
    o  = int'(addr);
    if (reset) begin
      for (int i = 0; i < NC; i++) begin m_act[k][i] = 8'h00; m_shd[k][i] = 8'h00; end
      m_ctrl[k] = 8'h70; m_cb[k] = 8'h00; m_off[k] = 8'h00; m_dbo[k] = 8'h00;
      m_zp[k]   = pal ? 16'h2730 : 16'h0084;
      m_dpph[k] = m_zp[k][15:8];
      m_rdy[k]  = 1'b1; m_pend[k] = 1'b0;
      return;
    end
    if (line_start) m_rdy[k] = 1'b1;
    if (pclk0 && cs && we_b) begin
      if (o == 8)      m_dbo[k] = status_read;
      else if (k == 0) m_dbo[k] = read_value(k, o);
      else             m_dbo[k] = 8'h00;
    end
    if (pclk0 && cs && !we_b) begin
      if (o == 0 || o % 4 != 0) begin
        idx = (o == 0) ? 0 : 3 * (o / 4) + o % 4;
        m_shd[k][idx] = db_in;
        if (sh) m_pend[k] = 1'b1;
        else    m_act[k][idx] = db_in;
      end else begin
        case (o)
          4:  m_rdy[k]  = 1'b0;
          12: m_dpph[k] = db_in;
          16: m_zp[k]   = {m_dpph[k], db_in};
          20: m_cb[k]   = db_in;
          24: m_off[k]  = db_in;
          28: m_ctrl[k] = db_in;
          default: ;
        endcase
      end
    end
    if (sh && line_start) begin
      for (int i = 0; i < NC; i++) m_act[k][i] = m_shd[k][i];
      m_pend[k] = 1'b0;
    end
  endtask

  function automatic exp_t snapshot(input int k);
    exp_t e;
    e.ctrl = m_ctrl[k]; e.cb = m_cb[k]; e.off = m_off[k]; e.dbo = m_dbo[k];
    e.zp = m_zp[k]; e.rdy = m_rdy[k]; e.pend = m_pend[k];
    for (int i = 0; i < NC; i++) e.cmap[i*8 +: 8] = m_act[k][i];
    return e;
  endfunction

  // One clock: model consumes the inputs present at the edge, expectations are queued.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    q0.push_back(snapshot(0));
    q1.push_back(snapshot(1));
    #1;
  endtask

  task automatic idle(input int n);
    pclk0 = 1'b0; cs = 1'b0; we_b = 1'b1; line_start = 1'b0; reset = 1'b0;
    repeat (n) step();
  endtask

  task automatic bus_op(input bit rd, input int o, input logic [7:0] d, input bit ls);
    pclk0 = 1'b1; cs = 1'b1; we_b = rd; addr = AW'(o); db_in = d; line_start = ls;
    step();
    idle(1);
  endtask

  task automatic do_reset(input bit p);
    reset = 1'b1; pal = p; pclk0 = 1'b0; cs = 1'b0; line_start = 1'b0;
    repeat (2) step();
    idle(1);
  endtask

  task automatic chk(input string name, input int k, input logic [CMW-1:0] act,
                     input logic [CMW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic compare(input int k, input exp_t e);
    chk("ctrl", k, CMW'(ctrl_o[k]), CMW'(e.ctrl));
    chk("char_base", k, CMW'(cb_o[k]), CMW'(e.cb));
    chk("offset", k, CMW'(off_o[k]), CMW'(e.off));
    chk("db_out", k, CMW'(dbo_o[k]), CMW'(e.dbo));
    chk("zp", k, CMW'(zp_o[k]), CMW'(e.zp));
    chk("ready", k, CMW'(rdy_o[k]), CMW'(e.rdy));
    chk("shadow_pending", k, CMW'(pend_o[k]), CMW'(e.pend));
    chk("color_map", k, cmap_o[k], e.cmap);
  endtask

  // Monitor: outputs settle after the edge; compare at the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  initial begin
    reset = 1'b1; pal = 1'b1; pclk0 = 1'b0; cs = 1'b0; we_b = 1'b1;
    addr = '0; db_in = 8'h00; status_read = 8'h00; line_start = 1'b0;

    do_reset(1'b1);
    do_reset(1'b0);

    bus_op(1'b0, 1, 8'h1A, 1'b0);
    idle(2);
    line_start = 1'b1; step(); idle(1);
    bus_op(1'b0, 2, 8'h55, 1'b1);

    bus_op(1'b0, 12, 8'h40, 1'b0);
    idle(1);
    bus_op(1'b0, 16, 8'h80, 1'b0);

    bus_op(1'b0, 4, 8'h00, 1'b0);
    idle(200);
    line_start = 1'b1; step(); idle(2);
    bus_op(1'b0, 4, 8'h00, 1'b1);
    idle(5);
    line_start = 1'b1; step(); idle(1);
    bus_op(1'b0, 4, 8'h00, 1'b0);
    idle(5);
    do_reset(1'b1);

    status_read = 8'h80;
    bus_op(1'b1, 8, 8'h00, 1'b0);
    bus_op(1'b0, 28, 8'h5A, 1'b0);
    bus_op(1'b1, 28, 8'h00, 1'b0);
    bus_op(1'b0, 61, 8'h77, 1'b0);
    line_start = 1'b1; step(); idle(1);
    bus_op(1'b0, 32, 8'hFF, 1'b0);
    bus_op(1'b1, 32, 8'h00, 1'b0);
    bus_op(1'b1, 61, 8'h00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      pclk0       = ($urandom % 4) != 0;
      cs          = ($urandom % 4) != 0;
      we_b        = $urandom % 2;
      addr        = AW'($urandom % 64);
      db_in       = 8'($urandom);
      status_read = 8'($urandom);
      line_start  = ($urandom % 16) == 0;
      reset       = ($urandom % 400) == 0;
      pal         = $urandom % 2;
      step();
    end
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d entries want 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
